// File: rtl/i2s_frame_sequencer.sv
// I2S frame sequencer: turns one L/R sample pair per frame into an I2S
// bit stream (sck/ws/sdo) and pops the control unit FIFOs with req_out.
// Frame = 64 slots of 2H clk each, H = 2 << rate_r.
module i2s_frame_sequencer #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOTS      = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  play_in,
  input  logic                  cfg_in,
  input  logic [1:0]            rate_in,
  input  logic [DATA_WIDTH-1:0] audio0_in,
  input  logic [DATA_WIDTH-1:0] audio1_in,
  output logic                  req_out,
  output logic                  sck_out,
  output logic                  ws_out,
  output logic                  sdo_out,
  output logic                  busy_out
);

  typedef enum logic [1:0] {IDLE, PLAY, FLUSH} state_t;

  state_t                state, state_nx;
  logic [1:0]            rate_r;
  logic [4:0]            div_cnt;   // 0..2H-1, up to 31 at rate 3
  logic [5:0]            slot_cnt;  // 0..SLOTS-1
  logic [DATA_WIDTH-1:0] lsh_r, rsh_r;
  logic                  req_r;

  logic [4:0] half;
  logic [5:0] per_m1;
  logic       div_last, frame_end, frame_start;
  logic       in_left, in_right;

  assign half        = 5'd2 << rate_r;
  assign per_m1      = {half, 1'b0} - 6'd1;
  assign div_last    = ({1'b0, div_cnt} == per_m1);
  assign frame_end   = div_last && (slot_cnt == 6'(SLOTS - 1));
  assign frame_start = (state == PLAY) && (div_cnt == '0) && (slot_cnt == '0);

  // Data slots sit one slot after the ws edge (I2S one-bit delay).
  assign in_left  = (slot_cnt >= 6'd1) && (slot_cnt <= 6'(DATA_WIDTH));
  assign in_right = (slot_cnt >= 6'(SLOTS/2 + 1)) &&
                    (slot_cnt <= 6'(SLOTS/2 + DATA_WIDTH));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state: a stop request always lets the current frame finish.
  // A stop seen on the very last clk of a frame needs no flush phase.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (play_in) state_nx = PLAY;
      PLAY:    if (!play_in) state_nx = frame_end ? IDLE : FLUSH;
      FLUSH:   if (play_in) state_nx = PLAY;
               else if (frame_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Rate is only taken while idle, so it changes at session boundaries only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        rate_r <= '0;
    else if (state == IDLE && cfg_in)  rate_r <= rate_in;
  end

  // Slot/divider counters; they wrap to 0 at frame end, including on return to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      slot_cnt <= '0;
    end else if (state == IDLE) begin
      div_cnt  <= '0;
      slot_cnt <= '0;
    end else if (div_last) begin
      div_cnt  <= '0;
      slot_cnt <= (slot_cnt == 6'(SLOTS - 1)) ? 6'd0 : slot_cnt + 6'd1;
    end else begin
      div_cnt  <= div_cnt + 5'd1;
    end
  end

  // Sample latch at frame start, then shift one bit per data slot (MSB first)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lsh_r <= '0;
      rsh_r <= '0;
    end else if (frame_start) begin
      lsh_r <= audio0_in;
      rsh_r <= audio1_in;
    end else if (state != IDLE && div_last) begin
      if (in_left)  lsh_r <= lsh_r << 1;
      if (in_right) rsh_r <= rsh_r << 1;
    end
  end

  // One-clk FIFO pop, the cycle after the latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_r <= 1'b0;
    else        req_r <= frame_start;
  end

  // Outputs decode registered state only, so they drop with reset at once
  // and ws/sdo move only when the counters step to div_cnt = 0.
  assign busy_out = (state != IDLE);
  assign req_out  = req_r;
  assign sck_out  = busy_out && (div_cnt >= half);
  assign ws_out   = busy_out && (slot_cnt >= 6'(SLOTS/2));
  assign sdo_out  = busy_out && ((in_left  && lsh_r[DATA_WIDTH-1]) ||
                                 (in_right && rsh_r[DATA_WIDTH-1]));

endmodule
